// File: rtl/plane_bus_writer.sv
// rtl/plane_bus_writer.sv - queued byte writer that strobes {rs, data} onto the plane controller bus
module plane_bus_writer #(
    parameter int D_WIDTH       = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 4,
    parameter int GAP_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] inData,
    input  logic               inRs,
    input  logic               inValid,
    output logic               inReady,
    output logic [D_WIDTH-1:0] dataOut,
    output logic               dataEn,
    output logic               rs,
    output logic               busy
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int MAX_CYC  = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [AW:0]   CNT_FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [CW-1:0] CYC_ONE     = CW'(1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Queue storage: each entry keeps the register select above the data byte.
    logic [D_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    state_t           state_q;
    logic [CW-1:0]    cyc_q;
    logic             data_en_q;
    logic [D_WIDTH-1:0] data_out_q;
    logic             rs_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [D_WIDTH:0] head;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Ready depends only on queue occupancy so upstream never sees a loop through inValid.
    assign inReady = !fifo_full;
    assign push    = inValid && !fifo_full;

    // The bus side only takes a new entry from IDLE, i.e. after the full gap has elapsed.
    assign pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign head = mem_q[rd_ptr_q];

    assign busy    = (state_q != ST_IDLE) || !fifo_empty;
    assign dataEn  = data_en_q;
    assign dataOut = data_out_q;
    assign rs      = rs_q;

    // Write accepted transfers into the slot under the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {inRs, inData};
        end
    end

    // Next pointer and occupancy values; a push and pop together cancel out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue bookkeeping registers; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Bus sequencer: strobe for STROBE_CYCLES, hold data through the gap, then one idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            data_en_q  <= 1'b0;
            data_out_q <= '0;
            rs_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        data_out_q <= head[D_WIDTH-1:0];
                        rs_q       <= head[D_WIDTH];
                        data_en_q  <= 1'b1;
                        cyc_q      <= STROBE_LOAD;
                        state_q    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (cyc_q == '0) begin
                        data_en_q <= 1'b0;
                        cyc_q     <= GAP_LOAD;
                        state_q   <= ST_GAP;
                    end else begin
                        cyc_q <= cyc_q - CYC_ONE;
                    end
                end
                ST_GAP: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cyc_q <= cyc_q - CYC_ONE;
                    end
                end
                default: begin
                    data_en_q <= 1'b0;
                    cyc_q     <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plane_bus_writer.sv
// tb/tb_plane_bus_writer.sv - self-checking bench for plane_bus_writer
module tb_plane_bus_writer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_rs;
    logic       in_valid;

    logic       rdy_a, en_a, rs_a, busy_a;
    logic [7:0] out_a;
    logic       rdy_b, en_b, rs_b, busy_b;
    logic [7:0] out_b;

    logic       sel;
    logic       act_rdy, act_en, act_rs, act_busy;
    logic [7:0] act_out;

    int total;
    int bad;

    // reference model: pending queue, cycles until the bus is free, item on the bus
    logic [8:0] m_q[$];
    int         m_rem;
    logic [8:0] m_cur;
    int         m_s, m_g, m_depth;
    logic       m_acc;

    // bus monitor
    logic       prev_en;
    int         low_run;
    logic [8:0] seen[$];
    int         runs[$];

    typedef struct {
        logic       v;
        logic       r;
        logic [7:0] d;
        logic       e_en;
        logic [7:0] e_out;
        logic       e_rs;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;
    vec_t tbl[11];

    plane_bus_writer dut_a (
        .clk(clk), .reset(rst_n), .inData(in_data), .inRs(in_rs), .inValid(in_valid),
        .inReady(rdy_a), .dataOut(out_a), .dataEn(en_a), .rs(rs_a), .busy(busy_a)
    );

    plane_bus_writer #(.D_WIDTH(8), .FIFO_DEPTH(2), .STROBE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .reset(rst_n), .inData(in_data), .inRs(in_rs), .inValid(in_valid),
        .inReady(rdy_b), .dataOut(out_b), .dataEn(en_b), .rs(rs_b), .busy(busy_b)
    );

    assign act_rdy  = sel ? rdy_b  : rdy_a;
    assign act_en   = sel ? en_b   : en_a;
    assign act_rs   = sel ? rs_b   : rs_a;
    assign act_busy = sel ? busy_b : busy_a;
    assign act_out  = sel ? out_b  : out_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rem   = 0;
        m_cur   = '0;
        m_acc   = 1'b0;
        prev_en = 1'b0;
        low_run = 0;
        seen.delete();
        runs.delete();
    endtask

    task automatic model_step();
        logic pop_now;
        logic acc_now;
        pop_now = (m_rem == 0) && (m_q.size() != 0);
        acc_now = in_valid && (m_q.size() < m_depth);
        if (m_rem > 0) m_rem--;
        if (pop_now) begin
            m_cur = m_q.pop_front();
            m_rem = m_s + m_g;
        end
        if (acc_now) m_q.push_back({in_rs, in_data});
        m_acc = acc_now;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("en",   32'(act_en),   32'(m_rem > m_g));
        chk("out",  32'(act_out),  32'(m_cur[7:0]));
        chk("rs",   32'(act_rs),   32'(m_cur[8]));
        chk("busy", 32'(act_busy), 32'((m_rem > 0) || (m_q.size() != 0)));
        chk("rdy",  32'(act_rdy),  32'(m_q.size() < m_depth));
        if (act_en && !prev_en) begin
            seen.push_back({act_rs, act_out});
            runs.push_back(low_run);
            low_run = 0;
        end
        if (!act_en) low_run++;
        prev_en = act_en;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_rs    = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!(m_rem == 0 && m_q.size() == 0) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(m_rem == 0 && m_q.size() == 0), 32'd1);
        tick();
    endtask

    task automatic push_list(input logic [8:0] items[$]);
        foreach (items[i]) begin
            in_valid = 1'b1;
            in_rs    = items[i][8];
            in_data  = items[i][7:0];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_seen(input string nm, input logic [8:0] exp[$]);
        chk({nm, "_count"}, 32'(seen.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < seen.size()) chk({nm, "_item"}, 32'(seen[i]), 32'(exp[i]));
        end
    endtask

    task automatic random_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_rs    = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            tick();
        end
        drain();
    endtask

    initial begin
        logic [8:0] items[$];
        int idx;
        int n;
        total = 0;
        bad   = 0;
        sel     = 1'b0;
        m_s     = 4;
        m_g     = 4;
        m_depth = 4;

        // reset state while reset is held
        in_valid = 1'b0;
        in_rs    = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        model_reset();
        #3;
        chk("rst_en",   32'(en_a),   32'd0);
        chk("rst_out",  32'(out_a),  32'd0);
        chk("rst_rs",   32'(rs_a),   32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rdy",  32'(rdy_a),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // single command, hand-written expected trace
        tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v;
            in_rs    = tbl[i].r;
            in_data  = tbl[i].d;
            tick();
            chk("tbl_en",   32'(en_a),   32'(tbl[i].e_en));
            chk("tbl_out",  32'(out_a),  32'(tbl[i].e_out));
            chk("tbl_rs",   32'(rs_a),   32'(tbl[i].e_rs));
            chk("tbl_busy", 32'(busy_a), 32'(tbl[i].e_busy));
            chk("tbl_rdy",  32'(rdy_a),  32'(tbl[i].e_rdy));
        end
        in_valid = 1'b0;

        // burst of four commands
        do_reset();
        items = '{9'h101, 9'h102, 9'h106, 9'h10C};
        foreach (items[i]) begin
            in_valid = 1'b1;
            in_rs    = items[i][8];
            in_data  = items[i][7:0];
            tick();
            chk("burst_rdy", 32'(rdy_a), 32'd1);
        end
        drain();
        check_seen("burst", items);
        for (int i = 1; i < runs.size(); i++) chk("burst_gap", 32'(runs[i]), 32'd5);

        // fill to full with six offered items
        do_reset();
        items = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h166};
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_rs    = items[idx][8];
            in_data  = items[idx][7:0];
            tick();
            if (m_acc) idx++;
        end
        chk("full_accepted", 32'(idx), 32'd5);
        chk("full_rdy", 32'(rdy_a), 32'd0);
        n = 0;
        while (idx < 6 && n < 50) begin
            in_valid = 1'b1;
            in_rs    = items[idx][8];
            in_data  = items[idx][7:0];
            tick();
            if (m_acc) idx++;
            n++;
        end
        chk("full_last_accepted", 32'(idx), 32'd6);
        drain();
        check_seen("full", items);

        // pixel data with rs low
        do_reset();
        items = '{9'h000, 9'h00F, 9'h0FF};
        push_list(items);
        drain();
        check_seen("mixed", items);

        // reset during the second strobe cycle with two entries queued
        do_reset();
        items = '{9'h1A1, 9'h0B2, 9'h1C3};
        push_list(items);
        chk("midrst_pre_en", 32'(en_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_en",   32'(en_a),   32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_rdy",  32'(rdy_a),  32'd1);
        chk("midrst_out",  32'(out_a),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        items = '{9'h15A};
        push_list(items);
        for (int c = 0; c < 20; c++) tick();
        check_seen("post_rst", items);

        // randomized traffic on default parameters
        do_reset();
        random_run(300);

        // small configuration: 1-cycle strobe, 1-cycle gap, depth 2
        sel     = 1'b1;
        m_s     = 1;
        m_g     = 1;
        m_depth = 2;
        do_reset();
        items = '{9'h1E1, 9'h0E2, 9'h1E3};
        push_list(items);
        chk("small_rdy_full", 32'(rdy_b), 32'd0);
        drain();
        check_seen("small", items);
        for (int i = 1; i < runs.size(); i++) chk("small_gap", 32'(runs[i]), 32'd2);
        do_reset();
        random_run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plane_bus_writer.md
PLANE_BUS_WRITER -- requirements
Module: plane_bus_writer

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the bus data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two ≥2, giving the queued-transfer capacity.
REQ-003 The block SHALL have parameter STROBE_CYCLES, default 4, range ≥1, giving the dataEn high time in clk cycles.
REQ-004 The block SHALL have parameter GAP_CYCLES, default 4, range ≥1, giving the dataEn low time after each strobe in clk cycles.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 inData  input  D_WIDTH  byte to transmit.
REQ-008 inRs  input  1  register select for inData: 1 = command, 0 = pixel data.
REQ-009 inValid  input  1  upstream offers {inRs, inData} this cycle.
REQ-010 inReady  output  1  block can accept a transfer this cycle.
REQ-011 dataOut  output  D_WIDTH  bus data to planeController dataIn.
REQ-012 dataEn  output  1  bus strobe to planeController dataEn.
REQ-013 rs  output  1  bus register select to planeController rs.
REQ-014 busy  output  1  high while any transfer is queued or on the bus.

Function
REQ-015 The block SHALL accept a transfer on every rising edge where inValid=1 and inReady=1, and ignore inData/inRs otherwise.
REQ-016 inReady SHALL equal NOT fifo-full, combinationally from registered state only (no dependence on inValid).
REQ-017 The FIFO SHALL store {inRs, inData} pairs in order, with wrap-around read/write pointers and an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-018 A simultaneous push and pop SHALL leave occupancy unchanged; a push when full and a pop when empty SHALL never occur.
REQ-019 The FSM SHALL have three states: IDLE, STROBE, GAP.
REQ-020 In IDLE with FIFO non-empty, the block SHALL pop the head on the next edge, load dataOut/rs, set dataEn=1, load the cycle counter with STROBE_CYCLES-1, and enter STROBE.
REQ-021 In STROBE, the counter SHALL decrement each cycle; at zero, dataEn SHALL go 0, the counter SHALL load GAP_CYCLES-1, and the FSM SHALL enter GAP.
REQ-022 In GAP, the counter SHALL decrement each cycle; at zero, the FSM SHALL enter IDLE.
REQ-023 dataEn SHALL be high for exactly STROBE_CYCLES consecutive cycles per transfer.
REQ-024 dataOut and rs SHALL remain stable from the strobe's first cycle until the last GAP cycle, so data holds around the falling dataEn edge.
REQ-025 Consecutive strobes SHALL be separated by GAP_CYCLES+1 low cycles (GAP plus one IDLE cycle).
REQ-026 Latency SHALL be two edges from acceptance into an empty, idle block to dataEn high: push at edge k, pop at edge k+1.
REQ-027 busy SHALL be 1 when the state is not IDLE or occupancy is non-zero, and 0 otherwise.
REQ-028 dataEn, dataOut and rs SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 While reset=0, the block SHALL hold: dataEn=0, dataOut=0, rs=0, state=IDLE, counter=0, FIFO pointers and occupancy=0, busy=0, inReady=1.
REQ-030 Reset asserted mid-transfer SHALL drop dataEn immediately (asynchronously) and discard all queued transfers.
REQ-031 After reset release, the first transfer SHALL obey REQ-026 with no spurious strobe.

Verification
REQ-032 Single command: push {rs=1, 0x01} into an idle block -> dataEn high 4 cycles starting 2 edges later, dataOut=0x01, rs=1 held 8 cycles, then busy=0.
REQ-033 Burst: push 0x01, 0x02, 0x06, 0x0C (rs=1) back-to-back -> inReady stays 1; 4 strobes in order, each 4 high, 5 low between.
REQ-034 Full: push 6 items without draining -> inReady=0 after 4 accepted (1 popped early, so 5 accepted total); order preserved; no item lost or duplicated.
REQ-035 Mixed rs: push {0,0x00}, {0,0x0F}, {0,0xFF} -> rs=0 on all strobes, dataOut matches in order.
REQ-036 Reset during STROBE cycle 2 of a transfer with 2 queued -> dataEn=0 at once, busy=0; after release, the next push produces exactly one strobe.
REQ-037 Parameter sweep: STROBE_CYCLES=1, GAP_CYCLES=1, FIFO_DEPTH=2 -> 1-cycle strobes, 2-cycle spacing, inReady=0 at occupancy 2.
